// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 mux datapath between four
//               level-request masters. It drives a one-hot grant, the mux
//               selects and a valid flag, all registered. While others wait,
//               a single tenure is limited to MAX_HOLD cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       sel1,
    output logic       sel0,
    output logic       valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_next_cnt;
    logic [1:0]        r_last;
    logic [1:0]        w_next_last;
    logic [3:0]        w_next_grant;
    logic [1:0]        w_next_sel;

    logic [1:0]        w_owner;
    logic [3:0]        w_cand;
    logic [1:0]        w_pick;
    logic              w_pick_ok;
    logic              w_take;

    // The current owner is whatever the select registers point at.
    assign w_owner = {sel1, sel0};

    // Arbitration candidates: while granted, the owner never competes with itself.
    always_comb begin
        w_cand = req;
        if (r_state == GRANT) begin
            w_cand = req & ~(4'b0001 << w_owner);
        end
    end

    // Rotating priority scan starting at last+1; later loop passes have higher priority.
    always_comb begin
        w_pick    = r_last;
        w_pick_ok = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (w_cand[r_last + 2'(k)]) begin
                w_pick    = r_last + 2'(k);
                w_pick_ok = 1'b1;
            end
        end
    end

    // Next-state and next-output decision for the tenure state machine.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = grant;
        w_next_sel   = w_owner;
        w_next_cnt   = r_cnt;
        w_next_last  = r_last;
        w_take       = 1'b0;

        case (r_state)
            IDLE: begin
                w_take = w_pick_ok;
            end
            GRANT: begin
                if (!req[w_owner]) begin
                    // Release: hand over directly if anyone else is waiting.
                    if (w_pick_ok) begin
                        w_take = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                        w_next_grant = 4'b0000;
                        w_next_cnt   = '0;
                    end
                end else if (r_cnt == HOLD_W'(MAX_HOLD)) begin
                    // Tenure expired: preempt if contended, otherwise restart it.
                    if (w_pick_ok) begin
                        w_take = 1'b1;
                    end else begin
                        w_next_cnt = HOLD_W'(1);
                    end
                end else begin
                    w_next_cnt = r_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = 4'b0000;
            end
        endcase

        if (w_take) begin
            w_next_state = GRANT;
            w_next_grant = 4'b0001 << w_pick;
            w_next_sel   = w_pick;
            w_next_cnt   = HOLD_W'(1);
            w_next_last  = w_pick;
        end
    end

    // State, tenure counter and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            grant   <= 4'b0000;
            sel1    <= 1'b0;
            sel0    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_last  <= w_next_last;
            grant   <= w_next_grant;
            sel1    <= w_next_sel[1];
            sel0    <= w_next_sel[0];
            valid   <= |w_next_grant;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Scoreboard bench for mux_rr_arbiter. A stimulus process drives
//               directed and random requests and pushes the reference model's
//               expected outputs; a monitor pops and compares at each negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int c_MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       sel1;
    logic       sel0;
    logic       valid;

    mux_rr_arbiter #(
        .MAX_HOLD(c_MAX_HOLD),
        .HOLD_W  (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .grant(grant),
        .sel1 (sel1),
        .sel0 (sel0),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected outputs after each edge: {grant[3:0], sel[1:0], valid}
    logic [6:0] sb[$];

    // Reference model state: owner index (-1 = none), cycles held, last winner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    int m_sel   = 0;

    function automatic int pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] q);
        logic [3:0] others;
        int p;
        if (r) begin
            m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
        end else if (m_owner < 0) begin
            p = pick(q, m_last);
            if (p >= 0) begin m_owner = p; m_held = 1; m_last = p; end
        end else begin
            others = q;
            others[m_owner] = 1'b0;
            p = pick(others, m_last);
            if (!q[m_owner]) begin
                if (p >= 0) begin m_owner = p; m_held = 1; m_last = p; end
                else m_owner = -1;
            end else if (m_held == c_MAX_HOLD) begin
                if (p >= 0) begin m_owner = p; m_held = 1; m_last = p; end
                else m_held = 1;
            end else begin
                m_held++;
            end
        end
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    task automatic cycle(input logic r, input logic [3:0] q);
        logic [3:0] g;
        rst = r;
        req = q;
        @(posedge clk);
        model_step(r, q);
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        sb.push_back({g, 2'(m_sel), (m_owner >= 0)});
        #1;
    endtask

    // Monitor: compares the DUT against the oldest expectation at each negedge.
    always @(negedge clk) begin
        logic [6:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (grant !== e[6:3]) begin
                n_err++;
                $display("FAIL grant t=%0t actual=%b required=%b", $time, grant, e[6:3]);
            end
            n_cmp++;
            if ({sel1, sel0} !== e[2:1]) begin
                n_err++;
                $display("FAIL sel t=%0t actual=%b required=%b", $time, {sel1, sel0}, e[2:1]);
            end
            n_cmp++;
            if (valid !== e[0]) begin
                n_err++;
                $display("FAIL valid t=%0t actual=%b required=%b", $time, valid, e[0]);
            end
            n_cmp++;
            if (!$onehot0(grant) || (valid !== |grant) ||
                (valid && (grant !== (4'b0001 << {sel1, sel0})))) begin
                n_err++;
                $display("FAIL consistency t=%0t actual grant=%b sel=%b valid=%b required onehot0/valid==|grant/sel==index",
                         $time, grant, {sel1, sel0}, valid);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        rst = 1'b1;
        req = 4'b0000;

        // Reset with all requests high, then first grant goes to requester 0.
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b1111);
        // Full contention: 8-cycle tenures rotating 0,1,2,3,0.
        repeat (42) cycle(1'b0, 4'b1111);

        // Single request from idle, then release to idle.
        cycle(1'b1, 4'b0000);
        repeat (3) cycle(1'b0, 4'b0100);
        repeat (2) cycle(1'b0, 4'b0000);

        // Owner 1 releases while 0 waits: wrap-around handover with no bubble.
        repeat (2) cycle(1'b0, 4'b0010);
        cycle(1'b0, 4'b0011);
        repeat (3) cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0000);

        // Lone requester holds past MAX_HOLD.
        repeat (20) cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0000);

        // Reset mid-tenure of owner 3, then requester 0 wins first.
        repeat (4) cycle(1'b0, 4'b1000);
        cycle(1'b1, 4'b1001);
        repeat (3) cycle(1'b0, 4'b1001);

        // Release coinciding with a new arrival.
        cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0000);

        // Random level requests with occasional resets.
        rq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            cycle(($urandom_range(0, 299) == 0), rq);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
